// File: rtl/key_matrix_scanner_if.sv
`default_nettype none
// ============================================================================
// key_matrix_scanner_if : ports of the key matrix scanner (control, row lines
//                         in, column strobe and debounced key map out)
// Revision 1.0
// ============================================================================
interface key_matrix_scanner_if #(
  parameter int N = 8
);
  localparam int XW = $clog2(N) + 1;

  logic            ena;
  logic [N-1:0]    rows_in;
  logic [N-1:0]    cols;
  logic [XW-1:0]   x;
  logic [N*N-1:0]  keys;
  logic            changed;
  logic            frame_done;

  modport master (
    output ena, rows_in,
    input  cols, x, keys, changed, frame_done
  );

  modport slave (
    input  ena, rows_in,
    output cols, x, keys, changed, frame_done
  );
endinterface
`default_nettype wire

// File: rtl/key_matrix_scanner.sv
`default_nettype none
// ============================================================================
// key_matrix_scanner : column-strobed NxN key matrix reader with a 2-flop row
//                      synchronizer and per-key debounce counters
// Revision 1.0
// ============================================================================
module key_matrix_scanner #(
  parameter int N              = 8,
  parameter int SETTLE_CYCLES  = 4,
  parameter int DEBOUNCE_SCANS = 3
) (
  input  logic                clk,
  input  logic                rst,
  key_matrix_scanner_if.slave bus
);

  localparam int XW = $clog2(N) + 1;
  localparam int SW = $clog2(SETTLE_CYCLES + 1);
  localparam int DW = $clog2(DEBOUNCE_SCANS + 1);
  localparam logic [XW-1:0] LAST_X = XW'(N - 1);

  if (N < 1 || N > 8) begin : g_chk_n
    $error("key_matrix_scanner: N must be in 1..8");
  end
  if (SETTLE_CYCLES < 3) begin : g_chk_settle
    $error("key_matrix_scanner: SETTLE_CYCLES must be >= 3");
  end
  if (DEBOUNCE_SCANS < 1) begin : g_chk_debounce
    $error("key_matrix_scanner: DEBOUNCE_SCANS must be >= 1");
  end

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DRIVE  = 2'd1,
    SAMPLE = 2'd2
  } state_t;

  state_t          state_q;
  logic [XW-1:0]   x_q;
  logic [SW-1:0]   cnt_q;
  logic [N-1:0]    cols_q;
  logic [N-1:0]    sync_q;
  logic [N-1:0]    rows_s_q;
  logic [N*N-1:0]  keys_q;
  logic [N*N-1:0]  keys_d;
  logic [DW-1:0]   dbc_q [N*N];
  logic [DW-1:0]   dbc_d [N*N];
  logic            changed_q;
  logic            changed_d;
  logic            frame_done_q;
  logic [XW-1:0]   x_d;

  assign x_d = (x_q == LAST_X) ? '0 : x_q + 1'b1;

  // Only the keys of the column currently being sampled may move.
  always_comb begin
    keys_d    = keys_q;
    changed_d = 1'b0;
    for (int i = 0; i < N * N; i++) begin
      dbc_d[i] = dbc_q[i];
    end
    if (state_q == SAMPLE) begin
      for (int r = 0; r < N; r++) begin
        for (int c = 0; c < N; c++) begin
          if (XW'(c) == x_q) begin
            if (rows_s_q[r] == keys_q[N*r+c]) begin
              dbc_d[N*r+c] = '0;
            end else if (dbc_q[N*r+c] == DW'(DEBOUNCE_SCANS - 1)) begin
              keys_d[N*r+c] = ~keys_q[N*r+c];
              dbc_d[N*r+c]  = '0;
              changed_d     = 1'b1;
            end else begin
              dbc_d[N*r+c] = dbc_q[N*r+c] + 1'b1;
            end
          end
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q      <= IDLE;
      x_q          <= '0;
      cnt_q        <= '0;
      cols_q       <= '0;
      sync_q       <= '0;
      rows_s_q     <= '0;
      keys_q       <= '0;
      changed_q    <= 1'b0;
      frame_done_q <= 1'b0;
      for (int i = 0; i < N * N; i++) begin
        dbc_q[i] <= '0;
      end
    end else begin
      sync_q       <= bus.rows_in;
      rows_s_q     <= sync_q;
      keys_q       <= keys_d;
      changed_q    <= changed_d;
      frame_done_q <= 1'b0;
      for (int i = 0; i < N * N; i++) begin
        dbc_q[i] <= dbc_d[i];
      end
      case (state_q)
        IDLE: begin
          if (bus.ena) begin
            state_q <= DRIVE;
            x_q     <= '0;
            cnt_q   <= '0;
            cols_q  <= N'(1);
          end
        end
        DRIVE: begin
          if (cnt_q == SW'(SETTLE_CYCLES - 1)) begin
            state_q <= SAMPLE;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        SAMPLE: begin
          frame_done_q <= (x_q == LAST_X);
          if (bus.ena) begin
            state_q <= DRIVE;
            x_q     <= x_d;
            cnt_q   <= '0;
            cols_q  <= N'(1) << x_d;
          end else begin
            // Stopping always rewinds so the next scan begins at column 0.
            state_q <= IDLE;
            x_q     <= '0;
            cols_q  <= '0;
          end
        end
        default: begin
          state_q <= IDLE;
          x_q     <= '0;
          cols_q  <= '0;
        end
      endcase
    end
  end

  assign bus.cols       = cols_q;
  assign bus.x          = x_q;
  assign bus.keys       = keys_q;
  assign bus.changed    = changed_q;
  assign bus.frame_done = frame_done_q;

endmodule
`default_nettype wire

// File: tb/tb_key_matrix_scanner.sv
`default_nettype none
// ============================================================================
// tb_key_matrix_scanner : directed vectors and multi-frame sequences for the
//                         key matrix scanner with a behavioural switch matrix
// Revision 1.0
// ============================================================================
module tb_key_matrix_scanner;

  localparam int N  = 8;
  localparam int XW = $clog2(N) + 1;
  localparam int NN = N * N;
  localparam logic [NN-1:0] K21  = 64'h0000_0000_0020_0000;
  localparam logic [NN-1:0] ALL1 = 64'hFFFF_FFFF_FFFF_FFFF;

  logic          clk = 1'b0;
  logic          rst;
  logic          rows_ff;
  logic [NN-1:0] pressed;
  logic [N-1:0]  model;

  int n_checks = 0;
  int n_pass   = 0;
  int t        = 0;
  int ch_cnt   = 0;
  int fd_cnt   = 0;
  int fd_bad   = 0;

  always #5 clk = ~clk;

  key_matrix_scanner_if #(.N(N)) bus ();

  key_matrix_scanner #(
    .N(N),
    .SETTLE_CYCLES(4),
    .DEBOUNCE_SCANS(3)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  // A closed switch connects its column strobe to its row line.
  always_comb begin
    model = '0;
    for (int r = 0; r < N; r++) begin
      model[r] = |(pressed[N*r +: N] & bus.cols);
    end
  end
  assign bus.rows_in = rows_ff ? '1 : model;

  typedef struct {
    logic          rst;
    logic [N-1:0]  cols;
    logic [XW-1:0] x;
    logic          fd;
  } vec_t;

  vec_t vecs[10];

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    t++;
    if (bus.changed) ch_cnt++;
    if (bus.frame_done) begin
      fd_cnt++;
      if (t % 40 != 1) fd_bad++;
    end
  endtask

  task automatic run_to(input int target);
    while (t < target) tick();
  endtask

  task automatic clear_counts();
    t = 0; ch_cnt = 0; fd_cnt = 0; fd_bad = 0;
  endtask

  task automatic do_reset();
    rst = 1'b0;
    repeat (3) tick();
    rst = 1'b1;
    clear_counts();
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    rst     = 1'b0;
    rows_ff = 1'b1;
    pressed = '0;
    bus.ena = 1'b1;

    // Reset held 3 cycles with all rows high, then the first column period.
    vecs[0] = '{1'b0, 8'h00, 4'd0, 1'b0};
    vecs[1] = '{1'b0, 8'h00, 4'd0, 1'b0};
    vecs[2] = '{1'b0, 8'h00, 4'd0, 1'b0};
    vecs[3] = '{1'b1, 8'h01, 4'd0, 1'b0};
    vecs[4] = '{1'b1, 8'h01, 4'd0, 1'b0};
    vecs[5] = '{1'b1, 8'h01, 4'd0, 1'b0};
    vecs[6] = '{1'b1, 8'h01, 4'd0, 1'b0};
    vecs[7] = '{1'b1, 8'h01, 4'd0, 1'b0};
    vecs[8] = '{1'b1, 8'h02, 4'd1, 1'b0};
    vecs[9] = '{1'b1, 8'h02, 4'd1, 1'b0};

    for (int i = 0; i < 10; i++) begin
      rst = vecs[i].rst;
      tick();
      check($sformatf("vec%0d {cols,x,keys,changed,frame_done}", i),
            {bus.cols, bus.x, bus.keys, bus.changed, bus.frame_done},
            {vecs[i].cols, vecs[i].x, 64'h0, 1'b0, vecs[i].fd});
    end
    rows_ff = 1'b0;

    // Single press of r2,c5: third column-5 sample is at cycle 110.
    do_reset();
    pressed[21] = 1'b1;
    run_to(110);
    check("press keys before 3rd sample", bus.keys, '0);
    tick();
    check("press keys after 3rd sample", bus.keys, K21);
    check("press changed pulse", bus.changed, 1'b1);
    tick();
    check("press changed one cycle", bus.changed, 1'b0);
    run_to(161);
    check("press keys held", bus.keys, K21);
    check("press changed count", ch_cnt, 1);
    check("press frame_done count", fd_cnt, 4);
    check("press frame_done period", fd_bad, 0);

    // Bounce: pressed on even frames, released on odd frames.
    do_reset();
    while (t < 240) begin
      pressed[21] = ((t / 40) % 2 == 0);
      tick();
    end
    check("bounce keys", bus.keys, '0);
    check("bounce changed count", ch_cnt, 0);
    check("bounce frame_done count", fd_cnt, 5);

    // Release after debounce: samples at 150, 190, 230.
    do_reset();
    pressed[21] = 1'b1;
    run_to(111);
    check("release precondition", bus.keys, K21);
    pressed[21] = 1'b0;
    ch_cnt = 0;
    run_to(230);
    check("release keys before 3rd sample", bus.keys, K21);
    tick();
    check("release keys cleared", bus.keys, '0);
    check("release changed pulse", bus.changed, 1'b1);
    run_to(240);
    check("release changed count", ch_cnt, 1);

    // ena dropped during DRIVE of column 3 in frame 3 (DRIVE 136..139, SAMPLE 140).
    do_reset();
    pressed[21] = 1'b1;
    run_to(136);
    bus.ena = 1'b0;
    run_to(140);
    check("ena drop col3 still sampled cols", bus.cols, 8'h08);
    check("ena drop col3 still sampled x", bus.x, 4'd3);
    tick();
    check("ena drop idle {cols,x,frame_done}", {bus.cols, bus.x, bus.frame_done}, {8'h00, 4'd0, 1'b0});
    run_to(145);
    check("ena drop stays idle", bus.cols, 8'h00);
    check("ena drop frame_done count", fd_cnt, 3);
    bus.ena = 1'b1;
    tick();
    check("ena restart {cols,x}", {bus.cols, bus.x}, {8'h01, 4'd0});
    check("ena restart keys kept", bus.keys, K21);
    pressed = '0;

    // All keys closed, then reset during column 4 of frame 3.
    do_reset();
    pressed = '1;
    run_to(81);
    check("all keys before frame 3", bus.keys, '0);
    run_to(121);
    check("all keys after frame 3", bus.keys, ALL1);
    check("all keys changed count", ch_cnt, 8);
    run_to(142);
    rst = 1'b0;
    tick();
    check("mid-frame reset {keys,cols,x}", {bus.keys, bus.cols, bus.x}, {64'h0, 8'h00, 4'd0});
    rst = 1'b1;
    clear_counts();
    run_to(120);
    check("re-debounce partial", bus.keys, 64'h7F7F_7F7F_7F7F_7F7F);
    tick();
    check("re-debounce full", bus.keys, ALL1);
    check("re-debounce changed count", ch_cnt, 8);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
